// File: rtl/icache_fetch.sv
// Instruction-fetch responder: direct-mapped, one word per line, filled from
// backing memory over a req/ack handshake while the PC is stalled.
module icache_fetch #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_req,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } state_t;

  state_t state;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill_done;

  assign idx       = pc_addr[IDX_W-1:0];
  assign tag       = pc_addr[ADDR_W-1:IDX_W];
  assign fill_idx  = mem_addr[IDX_W-1:0];
  assign fill_tag  = mem_addr[ADDR_W-1:IDX_W];
  assign fill_done = (state == FILL) && mem_ack;

  // A flush in the same cycle as a lookup forces a miss.
  assign hit   = pc_req && valid[idx] && (tags[idx] == tag) && !flush;
  assign stall = (state == FILL) || ((state == IDLE) && pc_req && !hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          if (pc_req && hit) begin
            instr       <= words[idx];
            instr_valid <= 1'b1;
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
          end else if (pc_req) begin
            instr_valid <= 1'b0;
            mem_addr    <= pc_addr;
            mem_req     <= 1'b1;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            state       <= FILL;
          end else begin
            instr_valid <= 1'b0;
          end
        end

        // The in-flight line is marked valid even if a flush lands on the ack edge.
        FILL: begin
          instr_valid <= 1'b0;
          if (mem_ack) begin
            valid       <= (flush ? '0 : valid) | (LINES'(1) << fill_idx);
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= RESP;
          end else if (flush) begin
            valid <= '0;
          end
        end

        RESP: begin
          if (flush) valid <= '0;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          instr_valid <= 1'b0;
          mem_req     <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && fill_done) begin
      tags[fill_idx]  <= fill_tag;
      words[fill_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: miss/fill, hits, aliasing, streaming,
// flush, reset mid-fill and counter saturation.
module tb_icache_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_req;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks;
  int errors;

  icache_fetch #(.LINES(8), .ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_req(pc_req), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete miss: request, n FILL cycles with the ack on the last,
  // one RESP cycle, then back to IDLE. Returns what was observed along the way.
  task automatic fill_cycle(input logic [31:0] addr, input logic [31:0] data,
                            input int n, output int stalls,
                            output logic [31:0] fill_addr, output logic fill_req,
                            output logic fill_valid, output logic resp_valid,
                            output logic [31:0] resp_instr, output logic resp_stall);
    pc_req = 1'b1;
    pc_addr = addr;
    #1;
    stalls = int'(stall);
    tick();
    fill_addr = mem_addr;
    fill_req = mem_req;
    fill_valid = instr_valid;
    for (int k = 1; k <= n; k++) begin
      stalls += int'(stall);
      if (k == n) begin
        mem_ack = 1'b1;
        mem_rdata = data;
      end
      tick();
    end
    mem_ack = 1'b0;
    pc_req = 1'b0;
    #1;
    resp_valid = instr_valid;
    resp_instr = instr;
    resp_stall = stall;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_req = 1'b0; pc_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks += 6;
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instr); end
    if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_counters: got %h/%h expected 0000/0000", hit_cnt, miss_cnt); end
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_miss_fill();
    int s; logic [31:0] fa; logic fr, fv, rv, rs; logic [31:0] ri;
    fill_cycle(32'd1, 32'hDEADBEEF, 3, s, fa, fr, fv, rv, ri, rs);
    checks += 7;
    if (s !== 4) begin errors++; $display("[TB] FAIL miss_stall_cycles: got %0d expected 4", s); end
    if (fa !== 32'd1 || fr !== 1'b1) begin errors++; $display("[TB] FAIL miss_mem_req: got addr %h req %b expected 00000001 1", fa, fr); end
    if (fv !== 1'b0) begin errors++; $display("[TB] FAIL miss_fill_valid: got %b expected 0", fv); end
    if (rv !== 1'b1) begin errors++; $display("[TB] FAIL miss_resp_valid: got %b expected 1", rv); end
    if (ri !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL miss_resp_instr: got %h expected deadbeef", ri); end
    if (rs !== 1'b0) begin errors++; $display("[TB] FAIL miss_resp_stall: got %b expected 0", rs); end
    if (miss_cnt !== 16'd1) begin errors++; $display("[TB] FAIL miss_cnt: got %0d expected 1", miss_cnt); end
  endtask

  task automatic test_hit();
    pc_req = 1'b1; pc_addr = 32'd1;
    #1;
    checks += 7;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL hit_stall: got %b expected 0", stall); end
    tick();
    if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL hit_valid: got %b expected 1", instr_valid); end
    if (instr !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL hit_instr: got %h expected deadbeef", instr); end
    if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL hit_mem_req: got %b expected 0", mem_req); end
    if (hit_cnt !== 16'd1) begin errors++; $display("[TB] FAIL hit_cnt: got %0d expected 1", hit_cnt); end
    pc_req = 1'b0;
    tick();
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %b expected 0", instr_valid); end
    if (instr !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL idle_instr_hold: got %h expected deadbeef", instr); end
  endtask

  task automatic test_alias();
    int s; logic [31:0] fa; logic fr, fv, rv, rs; logic [31:0] ri;
    fill_cycle(32'd9, 32'h99990009, 1, s, fa, fr, fv, rv, ri, rs);
    checks += 6;
    if (s !== 2 || fa !== 32'd9) begin errors++; $display("[TB] FAIL alias9_miss: got stalls %0d addr %h expected 2 00000009", s, fa); end
    if (ri !== 32'h99990009) begin errors++; $display("[TB] FAIL alias9_instr: got %h expected 99990009", ri); end
    fill_cycle(32'd1, 32'h11110001, 2, s, fa, fr, fv, rv, ri, rs);
    if (s !== 3) begin errors++; $display("[TB] FAIL alias1_stalls: got %0d expected 3", s); end
    if (fa !== 32'd1) begin errors++; $display("[TB] FAIL alias1_mem_addr: got %h expected 00000001", fa); end
    if (rv !== 1'b1 || ri !== 32'h11110001) begin errors++; $display("[TB] FAIL alias1_resp: got %b %h expected 1 11110001", rv, ri); end
    if (miss_cnt !== 16'd3) begin errors++; $display("[TB] FAIL alias_miss_cnt: got %0d expected 3", miss_cnt); end
  endtask

  task automatic test_back_to_back();
    int s; logic [31:0] fa; logic fr, fv, rv, rs; logic [31:0] ri;
    int stalls_seen, valids;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      if (i != 1) fill_cycle(32'(i), 32'hC0DE0000 | 32'(i), 1, s, fa, fr, fv, rv, ri, rs);
    end
    stalls_seen = 0;
    valids = 0;
    for (int i = 0; i < 8; i++) begin
      pc_req = 1'b1; pc_addr = 32'(i);
      #1;
      if (stall) stalls_seen++;
      tick();
      if (instr_valid) valids++;
      exp = (i == 1) ? 32'h11110001 : (32'hC0DE0000 | 32'(i));
      checks++;
      if (instr !== exp) begin errors++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", i, instr, exp); end
    end
    pc_req = 1'b0;
    tick();
    checks += 3;
    if (stalls_seen !== 0) begin errors++; $display("[TB] FAIL stream_stalls: got %0d expected 0", stalls_seen); end
    if (valids !== 8) begin errors++; $display("[TB] FAIL stream_valids: got %0d expected 8", valids); end
    if (hit_cnt !== 16'd9 || miss_cnt !== 16'd10) begin errors++; $display("[TB] FAIL stream_counters: got %0d/%0d expected 9/10", hit_cnt, miss_cnt); end
  endtask

  task automatic test_flush_fill();
    int s; logic [31:0] fa; logic fr, fv, rv, rs; logic [31:0] ri;
    pc_req = 1'b1; pc_addr = 32'd111111;
    tick();
    checks += 8;
    if (mem_req !== 1'b1 || mem_addr !== 32'd111111) begin errors++; $display("[TB] FAIL flush_fill_req: got %b %h expected 1 %h", mem_req, mem_addr, 32'd111111); end
    flush = 1'b1;
    #1;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_fill_stall: got %b expected 1", stall); end
    tick();
    flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0; pc_req = 1'b0;
    if (instr_valid !== 1'b1 || instr !== 32'h12345678) begin errors++; $display("[TB] FAIL flush_fill_resp: got %b %h expected 1 12345678", instr_valid, instr); end
    tick();
    pc_req = 1'b1; pc_addr = 32'd111111;
    #1;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_fill_rehit_stall: got %b expected 0", stall); end
    tick();
    if (instr_valid !== 1'b1 || instr !== 32'h12345678) begin errors++; $display("[TB] FAIL flush_fill_rehit: got %b %h expected 1 12345678", instr_valid, instr); end
    pc_req = 1'b0;
    tick();
    fill_cycle(32'd3, 32'hC0DE0003, 1, s, fa, fr, fv, rv, ri, rs);
    if (s !== 2) begin errors++; $display("[TB] FAIL flush_evicted_miss: got stalls %0d expected 2", s); end
    if (ri !== 32'hC0DE0003) begin errors++; $display("[TB] FAIL flush_evicted_instr: got %h expected c0de0003", ri); end
    if (hit_cnt !== 16'd10 || miss_cnt !== 16'd12) begin errors++; $display("[TB] FAIL flush_counters: got %0d/%0d expected 10/12", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    int s; logic [31:0] fa; logic fr, fv, rv, rs; logic [31:0] ri;
    pc_req = 1'b1; pc_addr = 32'd5;
    tick();
    checks += 10;
    if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstfill_req_before: got %b expected 1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; pc_req = 1'b0;
    if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstfill_req_after: got %b expected 0", mem_req); end
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rstfill_counters: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    mem_ack = 1'b1; mem_rdata = 32'h00000BAD;
    tick();
    mem_ack = 1'b0;
    if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("[TB] FAIL late_ack_ignored: got %b %h expected 0 00000000", instr_valid, instr); end
    fill_cycle(32'd5, 32'h55555555, 1, s, fa, fr, fv, rv, ri, rs);
    if (s !== 2 || fa !== 32'd5) begin errors++; $display("[TB] FAIL rstfill_remiss: got stalls %0d addr %h expected 2 00000005", s, fa); end
    if (miss_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rstfill_miss_cnt: got %0d expected 1", miss_cnt); end
    // Line 5 is now valid, but flush in the same cycle must force a miss.
    pc_req = 1'b1; pc_addr = 32'd5; flush = 1'b1;
    #1;
    if (stall !== 1'b1) begin errors++; $display("[TB] FAIL idle_flush_stall: got %b expected 1", stall); end
    tick();
    flush = 1'b0;
    if (mem_req !== 1'b1 || miss_cnt !== 16'd2) begin errors++; $display("[TB] FAIL idle_flush_miss: got %b %0d expected 1 2", mem_req, miss_cnt); end
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_ack = 1'b0; pc_req = 1'b0;
    if (instr_valid !== 1'b1 || instr !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL idle_flush_resp: got %b %h expected 1 5a5a5a5a", instr_valid, instr); end
    if (hit_cnt !== 16'd0) begin errors++; $display("[TB] FAIL idle_flush_hit_cnt: got %0d expected 0", hit_cnt); end
    tick();
  endtask

  task automatic test_saturate();
    pc_req = 1'b1; pc_addr = 32'd5;
    repeat (65534) tick();
    checks += 5;
    if (hit_cnt !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_pre: got %h expected fffe", hit_cnt); end
    tick();
    if (hit_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_reach: got %h expected ffff", hit_cnt); end
    repeat (5) tick();
    if (hit_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %h expected ffff", hit_cnt); end
    if (instr_valid !== 1'b1 || instr !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL sat_instr: got %b %h expected 1 5a5a5a5a", instr_valid, instr); end
    if (miss_cnt !== 16'd2) begin errors++; $display("[TB] FAIL sat_miss_cnt: got %0d expected 2", miss_cnt); end
    pc_req = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_alias();
    test_back_to_back();
    test_flush_fill();
    test_reset_mid_fill();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Instruction-fetch responder for the PC: accepts the word address the PC register drives each cycle and returns the instruction.
- Lookup goes through a small direct-mapped instruction cache; misses are filled from backing instruction memory over a req/ack handshake.
- Asserts stall back to the PC/pipeline control while a miss is outstanding.
- Sits between the PC stage and the IF/ID pipeline register.

Parameters:
- LINES, 8, number of cache lines; power of two, at least 2; one 32-bit word per line.
- ADDR_W, 32, PC/word-address width.
- DATA_W, 32, instruction width.
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_addr  input  ADDR_W  word address from PC out. Must be held stable while stall=1.
- pc_req  input  1  fetch request for pc_addr.
- flush  input  1  invalidate all lines.
- instr  output  DATA_W  fetched instruction.
- instr_valid  output  1  instr is valid this cycle.
- stall  output  1  combinational; PC must hold.
- mem_req  output  1  fill request to backing memory.
- mem_addr  output  ADDR_W  fill word address.
- mem_rdata  input  DATA_W  fill data, valid with mem_ack.
- mem_ack  input  1  one-cycle fill acknowledge.
- hit_cnt  output  CNT_W  saturating hit count.
- miss_cnt  output  CNT_W  saturating miss count.

Behaviour:
- Addressing: word addresses.
  - index = pc_addr[log2(LINES)-1:0]
  - tag = pc_addr[ADDR_W-1:log2(LINES)]
  - Per line: valid bit, tag, data word.
- hit = pc_req && valid[index] && tag match && !flush.
- Reset (rst=1 at an edge):
  - state=IDLE; all valid bits=0.
  - instr=0, instr_valid=0, mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
  - Reset during FILL abandons the fill: mem_req is 0 from the next cycle, and a late mem_ack is ignored.
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - pc_req && hit: instr <= line data; instr_valid <= 1 on the next cycle (1-cycle latency); hit_cnt increments; stay in IDLE. Back-to-back hits give one instruction per cycle.
  - pc_req && !hit: latch pc_addr into mem_addr; mem_req <= 1; miss_cnt increments; go to FILL.
  - !pc_req: instr_valid <= 0.
- FILL:
  - mem_req=1 and mem_addr held until mem_ack.
  - On mem_ack: write line[index of mem_addr] with valid=1, the tag, and mem_rdata; capture instr <= mem_rdata; mem_req <= 0; go to RESP.
  - mem_ack may arrive any number of cycles later, including 1.
- RESP: instr_valid=1 for exactly one cycle with the filled word; return to IDLE. The next request is looked up in the following cycle, so the just-filled line hits.
- stall = (state==FILL) || (state==IDLE && pc_req && !hit). stall is 0 in RESP.
- instr_valid is 0 in FILL. instr holds its last value when instr_valid=0.
- flush:
  - In IDLE, flush clears all valid bits at the edge. A pc_req in the same cycle is treated as a miss (flush has priority).
  - In FILL, flush clears all valid bits, but the in-flight fill still completes and writes its line valid.
  - In RESP, flush clears valid bits; the response is still delivered.
- Counters saturate at all-ones and do not wrap.
- A mem_ack outside FILL is ignored.
- Index aliasing: two addresses with equal index and different tag evict each other; no other state is affected.

Test Plan:
- Reset, then pc_req=1, pc_addr=1; memory acks after 3 cycles with 0xDEADBEEF:
  - stall=1 for the 4 cycles of IDLE-miss + FILL; mem_addr=1.
  - instr_valid=1 with instr=0xDEADBEEF in RESP.
  - miss_cnt=1.
- Re-request addr 1: instr=0xDEADBEEF on the next cycle with stall=0; no mem_req; hit_cnt=1.
- Alias: request 1 then 9 (LINES=8), each filled with distinct data; request 1 again -> miss, refill, mem_addr=1.
- Sequential stream 0..7 after warm-up -> 8 consecutive instr_valid cycles, zero stall.
- flush asserted during FILL for addr 111111 -> fill completes and instr delivered. Then addr 111111 hits; any other previously cached address misses.
- rst asserted mid-FILL -> next cycle mem_req=0, counters=0, request for the same addr misses again.
- Force hit_cnt to 0xFFFF via 65536+ hits -> stays 0xFFFF.
